main_memory_server: RTL

Synthesizable word-addressed backing memory with a fixed, parameterized access latency. It sits directly downstream of the L1-to-L2 request arbiter and serves that arbiter's `memory_if.requester` port. It accepts one LOAD or STORE at a time, counts out the latency, performs the array access, and pulses `req_fulfilled`. It is the system's last-level store, used in simulation and FPGA builds.

---
 rtl/main_memory_server_if.sv | 31 +++
 rtl/main_memory_server.sv | 129 ++++++++++++
 2 files changed

// File: rtl/main_memory_server_if.sv
// Operation-type package and the memory request bus shared by the L1-to-L2
// arbiter (requester side) and the backing memory (server side).
package torrence_params;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } mem_op_e;
endpackage

interface memory_if #(
  parameter int XLEN = 32
);
  import torrence_params::*;

  logic [XLEN-1:0] req_address;
  mem_op_e         req_operation;
  logic [XLEN-1:0] req_store_word;
  logic            req_valid;
  logic [XLEN-1:0] req_loaded_word;
  logic            req_fulfilled;

  modport requester (
    output req_address, req_operation, req_store_word, req_valid,
    input  req_loaded_word, req_fulfilled
  );

  modport server (
    input  req_address, req_operation, req_store_word, req_valid,
    output req_loaded_word, req_fulfilled
  );
endinterface

// File: rtl/main_memory_server.sv
// Word-addressed backing memory with a fixed access latency; one request at a time.
// Optional alignment checking is enabled by defining TORRENCE_MEM_ALIGN_CHECK_EN.
module main_memory_server
  import torrence_params::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic     clk,
  input  logic     reset,
  memory_if.server mem_if
`ifdef TORRENCE_MEM_ALIGN_CHECK_EN
  ,
  output logic     misaligned_error
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  mem_op_e         op_q, op_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            mis_req;
  logic            mem_we;
  logic            fulfilled;
  logic            mis_err;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

`ifdef TORRENCE_MEM_ALIGN_CHECK_EN
  assign mis_req = (mem_if.req_address[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_if.req_valid) state_d = (LATENCY == 1) ? ST_RESPOND : ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_if.req_valid) state_d = ST_IDLE;
        else if (cnt_q == 8'd1) state_d = ST_RESPOND;
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Loads present array data combinationally in the respond cycle and the
  // same value is registered so it holds afterwards.
  always_comb begin
    fulfilled = (state_q == ST_RESPOND);
    mis_err   = fulfilled && mis_q;
    mem_we    = fulfilled && (op_q == STORE) && !mis_q && !reset;
    rdata_d   = rdata_q;
    if (fulfilled) begin
      if (mis_q)             rdata_d = '0;
      else if (op_q == LOAD) rdata_d = mem_q[idx_q];
    end

    cnt_d   = cnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    if (state_q == ST_IDLE && mem_if.req_valid) begin
      cnt_d   = 8'(LATENCY - 1);
      idx_d   = mem_if.req_address[AW+1:2];
      op_d    = mem_if.req_operation;
      wdata_d = mem_if.req_store_word;
      mis_d   = mis_req;
    end else if (state_q == ST_WAIT && mem_if.req_valid) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= LOAD;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // NOTE: the array is deliberately not reset; clearing it would defeat
  // RAM inference and contents are defined to survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign mem_if.req_fulfilled   = fulfilled;
  assign mem_if.req_loaded_word = rdata_d;
`ifdef TORRENCE_MEM_ALIGN_CHECK_EN
  assign misaligned_error = mis_err;
`endif

endmodule
